// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package button_pkg;

   // Debounce FSM states; all four 2-bit codes are assigned.
   typedef enum logic [1:0] {
      S_LOW      = 2'b00,
      S_CHK_HIGH = 2'b01,
      S_HIGH     = 2'b10,
      S_CHK_LOW  = 2'b11
   } state_e;

   localparam logic [7:0] GLITCH_MAX = 8'd255;

   // Saturating increment for the glitch diagnostic counter.
   function automatic logic [7:0] glitch_inc(input logic [7:0] v);
      return (v == GLITCH_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins, with a selectable reset level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstN,
   input  logic d_i,
   output logic q_o
);

   logic ff1_q;
   logic ff2_q;

   // Two back-to-back flops to resolve metastability on the async input.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ff1_q <= RESET_VAL;
         ff2_q <= RESET_VAL;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
      end
   end

   assign q_o = ff2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw pin, requires a stable window
// before accepting a level change, emits rise/fall strobes and counts
// rejected transitions.
module button_debouncer
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter int unsigned CNT_WIDTH       = 17,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       btnRaw,
   output logic       goLevel,
   output logic       goRise,
   output logic       goFall,
   output logic [7:0] glitchCount
);

   // Synchronizer idles at the raw level that means "not pressed".
   localparam logic                 SYNC_RST = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 btnRawSync;
   logic                 btnSync;
   state_e               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 goLevel_q;
   logic                 goRise_q;
   logic                 goFall_q;
   logic [7:0]           glitch_q;

   sync_2ff #(
      .RESET_VAL (SYNC_RST)
   ) u_sync (
      .clk  (clk),
      .rstN (rstN),
      .d_i  (btnRaw),
      .q_o  (btnRawSync)
   );

   // Polarity correction after synchronization: 1 always means pressed.
   always_comb begin
      btnSync = BTN_ACTIVE_LOW ? ~btnRawSync : btnRawSync;
   end

   // Debounce FSM with stability counter, registered level, strobes and glitch count.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_LOW;
         cnt_q     <= '0;
         goLevel_q <= 1'b0;
         goRise_q  <= 1'b0;
         goFall_q  <= 1'b0;
         glitch_q  <= '0;
      end else begin
         goRise_q <= 1'b0;
         goFall_q <= 1'b0;
         case (state_q)
            S_LOW: begin
               if (btnSync) begin
                  cnt_q   <= '0;
                  state_q <= S_CHK_HIGH;
               end
            end
            S_CHK_HIGH: begin
               if (!btnSync) begin
                  state_q  <= S_LOW;
                  glitch_q <= glitch_inc(glitch_q);
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= S_HIGH;
                  goLevel_q <= 1'b1;
                  goRise_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            S_HIGH: begin
               if (!btnSync) begin
                  cnt_q   <= '0;
                  state_q <= S_CHK_LOW;
               end
            end
            S_CHK_LOW: begin
               if (btnSync) begin
                  state_q  <= S_HIGH;
                  glitch_q <= glitch_inc(glitch_q);
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= S_LOW;
                  goLevel_q <= 1'b0;
                  goFall_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_q   <= S_LOW;
               cnt_q     <= '0;
               goLevel_q <= 1'b0;
               goRise_q  <= 1'b0;
               goFall_q  <= 1'b0;
               glitch_q  <= '0;
            end
         endcase
      end
   end

   assign goLevel     = goLevel_q;
   assign goRise      = goRise_q;
   assign goFall      = goFall_q;
   assign glitchCount = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with a short debounce window.
module tb_button_debouncer;

   localparam int unsigned DC = 4;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       btnRaw = 1'b1;
   logic       goLevel;
   logic       goRise;
   logic       goFall;
   logic [7:0] glitchCount;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: pressed level seen through a 2-deep delay line,
   // plus the length of the current run of samples disagreeing with the level.
   logic m_p1, m_p2, m_level, m_rise, m_fall;
   int   m_run, m_glitch;

   int edge_no, rise_cnt, fall_cnt, first_rise_edge;

   typedef struct {
      logic       raw;
      logic       lvl;
      logic       rise;
      logic       fall;
      logic [7:0] glitch;
   } vec_t;
   vec_t tbl[20];

   button_debouncer #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_WIDTH       (3),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .rstN        (rstN),
      .btnRaw      (btnRaw),
      .goLevel     (goLevel),
      .goRise      (goRise),
      .goFall      (goFall),
      .glitchCount (glitchCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_run = 0; m_glitch = 0;
   endtask

   // A level change is accepted once DC+1 consecutive samples disagree with it;
   // a run that ends early counts as one rejected transition.
   task automatic model_edge(input logic raw);
      logic x;
      x = m_p2;
      m_p2 = m_p1;
      m_p1 = (raw == 1'b0);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (x != m_level) begin
         m_run++;
         if (m_run == int'(DC) + 1) begin
            m_level = x;
            m_rise = x;
            m_fall = ~x;
            m_run = 0;
         end
      end else begin
         if (m_run > 0 && m_glitch < 255) m_glitch++;
         m_run = 0;
      end
   endtask

   task automatic tick(input logic raw);
      btnRaw = raw;
      @(posedge clk);
      edge_no++;
      model_edge(raw);
      #1;
      chk("level", 32'(goLevel), 32'(m_level));
      chk("rise", 32'(goRise), 32'(m_rise));
      chk("fall", 32'(goFall), 32'(m_fall));
      chk("glitch", 32'(glitchCount), 32'(m_glitch));
      if (goRise === 1'b1) begin
         rise_cnt++;
         if (first_rise_edge < 0) first_rise_edge = edge_no;
      end
      if (goFall === 1'b1) fall_cnt++;
   endtask

   task automatic do_reset(input logic raw, input int n);
      btnRaw = raw;
      rstN = 1'b0;
      #1;
      model_reset();
      chk("rst_level", 32'(goLevel), 32'd0);
      chk("rst_rise", 32'(goRise), 32'd0);
      chk("rst_fall", 32'(goFall), 32'd0);
      chk("rst_glitch", 32'(glitchCount), 32'd0);
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("rst_hold_rise", 32'(goRise), 32'd0);
         chk("rst_hold_level", 32'(goLevel), 32'd0);
      end
      @(negedge clk);
      rstN = 1'b1;
      edge_no = 0;
      rise_cnt = 0;
      fall_cnt = 0;
      first_rise_edge = -1;
   endtask

   initial begin
      // Clean press for 10 edges then release: rise on edge 7, fall on edge 17.
      for (int i = 0; i < 20; i++) begin
         tbl[i].raw    = (i + 1 <= 10) ? 1'b0 : 1'b1;
         tbl[i].lvl    = (i + 1 >= 7) && (i + 1 < 17);
         tbl[i].rise   = (i + 1 == 7);
         tbl[i].fall   = (i + 1 == 17);
         tbl[i].glitch = 8'd0;
      end

      do_reset(1'b1, 3);
      for (int i = 0; i < 20; i++) begin
         tick(tbl[i].raw);
         chk("tbl_level", 32'(goLevel), 32'(tbl[i].lvl));
         chk("tbl_rise", 32'(goRise), 32'(tbl[i].rise));
         chk("tbl_fall", 32'(goFall), 32'(tbl[i].fall));
         chk("tbl_glitch", 32'(glitchCount), 32'(tbl[i].glitch));
      end
      chk("clean_rise_cnt", 32'(rise_cnt), 32'd1);
      chk("clean_fall_cnt", 32'(fall_cnt), 32'd1);

      // Button held through reset release.
      do_reset(1'b0, 3);
      repeat (12) tick(1'b0);
      chk("held_first_rise", 32'(first_rise_edge), 32'd7);
      chk("held_rise_cnt", 32'(rise_cnt), 32'd1);
      repeat (10) tick(1'b1);

      // Short glitch: 3 low cycles.
      do_reset(1'b1, 2);
      repeat (3) tick(1'b0);
      repeat (10) tick(1'b1);
      chk("glitch_cnt", 32'(glitchCount), 32'd1);
      chk("glitch_rise_cnt", 32'(rise_cnt), 32'd0);
      chk("glitch_level", 32'(goLevel), 32'd0);

      // Bounce burst, then hold pressed.
      do_reset(1'b1, 2);
      for (int i = 0; i < 12; i++) tick(((i % 4) < 2) ? 1'b0 : 1'b1);
      repeat (10) tick(1'b0);
      chk("bounce_first_rise", 32'(first_rise_edge), 32'd19);
      chk("bounce_rise_cnt", 32'(rise_cnt), 32'd1);
      chk("bounce_glitch", 32'(glitchCount), 32'd3);

      // Reset asserted two cycles into the press check.
      do_reset(1'b1, 2);
      repeat (5) tick(1'b0);
      do_reset(1'b1, 3);
      repeat (15) tick(1'b1);
      chk("midreset_rise_cnt", 32'(rise_cnt), 32'd0);

      // Glitch counter saturation.
      do_reset(1'b1, 2);
      repeat (300) begin
         repeat (2) tick(1'b0);
         repeat (3) tick(1'b1);
      end
      chk("sat_255", 32'(glitchCount), 32'd255);
      repeat (5) begin
         repeat (2) tick(1'b0);
         repeat (3) tick(1'b1);
      end
      chk("sat_hold", 32'(glitchCount), 32'd255);

      // Randomized segments against the model, with occasional resets.
      do_reset(1'b1, 2);
      for (int s = 0; s < 400; s++) begin
         logic r;
         int   len;
         r = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 9));
         if ($urandom_range(0, 49) == 0) do_reset(r, 1);
         repeat (len) tick(r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
